// File: rtl/tpumac_pipe.sv
// Systolic signed multiply-accumulate cell with optional product register,
// saturating or wrapping accumulate, sticky overflow and accumulate counter.
module tpumac_pipe #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int PIPE    = 1,
   parameter int SAT     = 1,
   parameter int CNT_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      WrEn,
   input  logic                      clr,
   input  logic signed [BITS_AB-1:0] Ain,
   input  logic signed [BITS_AB-1:0] Bin,
   input  logic signed [BITS_C-1:0]  Cin,
   output logic signed [BITS_AB-1:0] Aout,
   output logic signed [BITS_AB-1:0] Bout,
   output logic signed [BITS_C-1:0]  Cout,
   output logic                      ovf,
   output logic [CNT_W-1:0]          acc_cnt
);

   if (BITS_C < 2*BITS_AB) begin : g_bad_w
      $error("tpumac_pipe: BITS_C must be >= 2*BITS_AB");
   end

   logic signed [BITS_AB-1:0]   a_q, b_q;
   logic signed [BITS_C-1:0]    c_q, c_d;
   logic                        ovf_q, ovf_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic signed [2*BITS_AB-1:0] prod;
   logic signed [BITS_C-1:0]    prod_x;
   logic signed [BITS_C-1:0]    addend;
   logic                        add_vld;
   logic signed [BITS_C:0]      sum;
   logic                        ovf_now;
   logic signed [BITS_C-1:0]    sat_val, res;
   logic                        do_clr, do_ld, do_acc;

   assign prod   = Ain * Bin;
   assign prod_x = BITS_C'(prod);

   if (PIPE == 1) begin : g_pipe
      logic signed [BITS_C-1:0] p_q;
      logic                     pv_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            p_q  <= '0;
            pv_q <= 1'b0;
         end else begin
            if (en) p_q <= prod_x;
            if (clr) pv_q <= 1'b0;
            else if (en) pv_q <= !WrEn;
         end
      end
      assign addend  = p_q;
      assign add_vld = pv_q;
   end else if (PIPE == 0) begin : g_comb
      assign addend  = prod_x;
      assign add_vld = 1'b1;
   end else begin : g_bad_pipe
      $error("tpumac_pipe: PIPE must be 0 or 1");
   end

   // One extra bit catches overflow in both directions.
   assign sum     = {c_q[BITS_C-1], c_q} + {addend[BITS_C-1], addend};
   assign ovf_now = sum[BITS_C] ^ sum[BITS_C-1];
   assign sat_val = sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}}
                                : {1'b0, {(BITS_C-1){1'b1}}};
   assign res     = (SAT != 0 && ovf_now) ? sat_val : sum[BITS_C-1:0];

   assign do_clr = clr;
   assign do_ld  = !clr && en && WrEn;
   assign do_acc = !clr && en && !WrEn && add_vld;

   always_comb begin
      c_d   = c_q;
      ovf_d = ovf_q;
      cnt_d = cnt_q;
      unique case (1'b1)
         do_clr: begin
            c_d   = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
         end
         do_ld: begin
            c_d   = Cin;
            cnt_d = '0;
         end
         do_acc: begin
            c_d   = res;
            ovf_d = ovf_q | ovf_now;
            cnt_d = cnt_q + CNT_W'(cnt_q != '1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (en) begin
            a_q <= Ain;
            b_q <= Bin;
         end
         c_q   <= c_d;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end

   assign Aout    = a_q;
   assign Bout    = b_q;
   assign Cout    = c_q;
   assign ovf     = ovf_q;
   assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_tpumac_pipe.sv
// Bench for tpumac_pipe: vector table through a scoreboard queue, plus
// hand-written reset, hold and counter-saturation sequences.
module tb_tpumac_pipe;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en, WrEn, clr;
   logic signed [7:0] Ain, Bin;
   logic signed [15:0] Cin;
   logic signed [7:0] Aout, Bout, w_aout, w_bout;
   logic signed [15:0] Cout, w_cout;
   logic              ovf, w_ovf;
   logic [7:0]        acc_cnt, w_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .PIPE(1), .SAT(1), .CNT_W(8))
   u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr),
      .Ain(Ain), .Bin(Bin), .Cin(Cin),
      .Aout(Aout), .Bout(Bout), .Cout(Cout), .ovf(ovf), .acc_cnt(acc_cnt)
   );

   tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .PIPE(1), .SAT(0), .CNT_W(8))
   u_wrap (
      .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .clr(clr),
      .Ain(Ain), .Bin(Bin), .Cin(Cin),
      .Aout(w_aout), .Bout(w_bout), .Cout(w_cout), .ovf(w_ovf),
      .acc_cnt(w_cnt)
   );

   typedef struct {
      logic en, we, clr;
      int   a, b, cin;
      int   cout;
      logic ovf;
      int   cnt, aout, bout;
      int   wrap;
      bit   chkw;
   } vec_t;

   vec_t tbl[18];
   vec_t sb[$];

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, we, c, input int a, b, ci,
                               input int co, input logic o, input int cn,
                               input int ao, bo, wr, input bit cw);
      vec_t v;
      v.en = e; v.we = we; v.clr = c; v.a = a; v.b = b; v.cin = ci;
      v.cout = co; v.ovf = o; v.cnt = cn; v.aout = ao; v.bout = bo;
      v.wrap = wr; v.chkw = cw;
      return v;
   endfunction

   task automatic step(input vec_t v, input string nm);
      vec_t e;
      en   = v.en;
      WrEn = v.we;
      clr  = v.clr;
      Ain  = 8'(v.a);
      Bin  = 8'(v.b);
      Cin  = 16'(v.cin);
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({nm, ".Cout"}, int'(Cout), e.cout);
      check({nm, ".ovf"}, int'(ovf), int'(e.ovf));
      check({nm, ".acc_cnt"}, int'(acc_cnt), e.cnt);
      check({nm, ".Aout"}, int'(Aout), e.aout);
      check({nm, ".Bout"}, int'(Bout), e.bout);
      if (e.chkw) check({nm, ".wrapCout"}, int'(w_cout), e.wrap);
   endtask

   initial begin
      vec_t v;
      //              en we clr  A    B    Cin     Cout  ovf cnt Ao  Bo  wrap
      tbl[0]  = mk(1, 0, 1,   0,   0,      0,      0, 0, 0,   0,  0,      0, 1);
      tbl[1]  = mk(1, 1, 0,   0,   0,    100,    100, 0, 0,   0,  0,    100, 1);
      tbl[2]  = mk(1, 0, 0,   3,   4,      0,    100, 0, 0,   3,  4,    100, 1);
      tbl[3]  = mk(1, 0, 0,   3,   4,      0,    112, 0, 1,   3,  4,    112, 1);
      tbl[4]  = mk(1, 0, 0,   0,   0,      0,    124, 0, 2,   0,  0,    124, 1);
      tbl[5]  = mk(1, 1, 0,   0,   0,  32700,  32700, 0, 0,   0,  0,  32700, 1);
      tbl[6]  = mk(1, 0, 0, 127, 127,      0,  32700, 0, 0, 127,127,  32700, 1);
      tbl[7]  = mk(1, 0, 0, 127, 127,      0,  32767, 1, 1, 127,127, -16707, 1);
      tbl[8]  = mk(1, 1, 0,   0,   0,      0,      0, 1, 0,   0,  0,      0, 1);
      tbl[9]  = mk(1, 0, 1,   0,   0,      0,      0, 0, 0,   0,  0,      0, 1);
      tbl[10] = mk(1, 1, 0,   0,   0, -32700, -32700, 0, 0,   0,  0, -32700, 1);
      tbl[11] = mk(1, 0, 0,-128, 127,      0, -32700, 0, 0,-128,127, -32700, 1);
      tbl[12] = mk(1, 0, 0,   0,   0,      0, -32768, 1, 1,   0,  0,  16580, 1);
      tbl[13] = mk(1, 0, 0,   3,   4,      0, -32768, 1, 2,   3,  4,  16580, 1);
      tbl[14] = mk(0, 0, 1,   9,   9,      0,      0, 0, 0,   3,  4,      0, 1);
      tbl[15] = mk(1, 0, 0,   0,   0,      0,      0, 0, 0,   0,  0,      0, 1);
      tbl[16] = mk(1, 0, 0,   5,   6,      0,      0, 0, 1,   5,  6,      0, 1);
      tbl[17] = mk(1, 0, 0,   2,   3,      0,     30, 0, 2,   2,  3,     30, 1);

      rst_n = 1'b0; en = 1'b0; WrEn = 1'b0; clr = 1'b0;
      Ain = '0; Bin = '0; Cin = '0;
      #12;
      check("reset.Cout", int'(Cout), 0);
      check("reset.ovf", int'(ovf), 0);
      check("reset.acc_cnt", int'(acc_cnt), 0);
      check("reset.Aout", int'(Aout), 0);
      check("reset.Bout", int'(Bout), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
         if (i == 12) check("vec12.wrapOvf", int'(w_ovf), 1);
      end

      // Idle cycles with toggling inputs must not disturb any state, P included.
      for (int i = 0; i < 5; i++) begin
         v = mk(0, 1'($urandom_range(0, 1)), 0,
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 65535)) - 32768,
                30, 0, 2, 2, 3, 0, 0);
         step(v, $sformatf("hold%0d", i));
      end
      step(mk(1, 0, 0, 0, 0, 0, 36, 0, 3, 0, 0, 0, 0), "resume");

      for (int i = 0; i < 300; i++) begin
         v = mk(1, 0, 0, 0, 0, 0, 36, 0, (4 + i > 255) ? 255 : 4 + i,
                0, 0, 0, 0);
         step(v, $sformatf("cnt%0d", i));
      end

      step(mk(1, 1, 0, 0, 0, 50, 50, 0, 0, 0, 0, 0, 0), "rld");
      step(mk(1, 0, 0, 1, 1, 0, 50, 0, 0, 1, 1, 0, 0), "racc0");
      step(mk(1, 0, 0, 1, 1, 0, 51, 0, 1, 1, 1, 0, 0), "racc1");
      step(mk(1, 0, 0, 1, 1, 0, 52, 0, 2, 1, 1, 0, 0), "racc2");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst.Cout", int'(Cout), 0);
      check("arst.ovf", int'(ovf), 0);
      check("arst.acc_cnt", int'(acc_cnt), 0);
      check("arst.Aout", int'(Aout), 0);
      check("arst.Bout", int'(Bout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0), "post0");
      step(mk(1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0, 0), "post1");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
